// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - opcode, alu_op and state encodings for the multicycle control unit
package cpu_ctrl_pkg;

  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JUMP   = 7'b1101111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_ALU_R  = 3'd1,
    CLS_ALU_I  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_JUMP   = 3'd4,
    CLS_LOAD   = 3'd5,
    CLS_STORE  = 3'd6
  } instr_class_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - control unit to datapath signal bundle; PERF_CNT_EN adds instr_retired
interface multicycle_control_unit_if #(
  parameter int ALU_OP_W = 2
);
  logic [6:0]          opcode;
  logic                branch_flag;
  logic                mem_ready;
  logic                pc_write;
  logic                ir_write;
  logic [ALU_OP_W-1:0] alu_op;
  logic                alu_src;
  logic                mem_read;
  logic                mem_write;
  logic                mem_2_reg;
  logic                reg_write;
  logic                branch;
  logic                jump;
  logic                IF_flush;
  logic [2:0]          state;
  logic                illegal;
  logic                mem_error;
`ifdef PERF_CNT_EN
  logic [31:0]         instr_retired;
`endif

  modport master (
    input  opcode, branch_flag, mem_ready,
    output pc_write, ir_write, alu_op, alu_src, mem_read, mem_write,
           mem_2_reg, reg_write, branch, jump, IF_flush, state, illegal, mem_error
`ifdef PERF_CNT_EN
    , output instr_retired
`endif
  );

  modport slave (
    output opcode, branch_flag, mem_ready,
    input  pc_write, ir_write, alu_op, alu_src, mem_read, mem_write,
           mem_2_reg, reg_write, branch, jump, IF_flush, state, illegal, mem_error
`ifdef PERF_CNT_EN
    , input instr_retired
`endif
  );
endinterface

// File: rtl/opcode_decoder.sv
// rtl/opcode_decoder.sv - maps a 7-bit opcode to an instruction class and a legal bit
module opcode_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [6:0]   op,
  output instr_class_t cls,
  output logic         legal
);

  always_comb begin
    cls   = CLS_NONE;
    legal = 1'b1;
    case (op)
      OP_ALU_R:  cls = CLS_ALU_R;
      OP_ALU_I:  cls = CLS_ALU_I;
      OP_BRANCH: cls = CLS_BRANCH;
      OP_JUMP:   cls = CLS_JUMP;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - FETCH/DECODE/EXEC/MEM/WB control FSM with memory wait timeout
// Optional retired-instruction counter enabled by defining PERF_CNT_EN.
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int ALU_OP_W    = 2
) (
  input logic                        clk,
  input logic                        arst_n,
  multicycle_control_unit_if.master  bus
);

  state_t       state_q, state_d;
  logic [6:0]   op_q;
  logic [7:0]   wait_q, wait_d;
  logic         illegal_q, mem_error_q;
  logic         set_illegal, set_mem_error;
  logic         mem_phase, timeout;
  logic [6:0]   dec_op;
  instr_class_t cls;
  logic         legal;

  // DECODE judges the live opcode; later states use the latched copy
  assign dec_op = (state_q == ST_DECODE) ? bus.opcode : op_q;

  opcode_decoder u_dec (
    .op    (dec_op),
    .cls   (cls),
    .legal (legal)
  );

  assign mem_phase = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign timeout   = mem_phase && !bus.mem_ready && (wait_q == 8'(MEM_TIMEOUT));

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q     <= ST_FETCH;
      op_q        <= '0;
      wait_q      <= '0;
      illegal_q   <= 1'b0;
      mem_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == ST_DECODE) op_q <= bus.opcode;
      if (set_illegal)          illegal_q <= 1'b1;
      if (set_mem_error)        mem_error_q <= 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    set_illegal   = 1'b0;
    set_mem_error = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (bus.mem_ready) begin
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d       = ST_FETCH;
          set_mem_error = 1'b1;
        end
      end
      ST_DECODE: begin
        if (legal) begin
          state_d = ST_EXEC;
        end else begin
          state_d     = ST_FETCH;
          set_illegal = 1'b1;
        end
      end
      ST_EXEC: begin
        case (cls)
          CLS_ALU_R, CLS_ALU_I: state_d = ST_WB;
          CLS_LOAD, CLS_STORE:  state_d = ST_MEM;
          default:              state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (bus.mem_ready) begin
          state_d = (cls == CLS_LOAD) ? ST_WB : ST_FETCH;
        end else if (timeout) begin
          state_d       = ST_FETCH;
          set_mem_error = 1'b1;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      default: state_d = ST_FETCH;
    endcase
  end

  // Any state entry, including FETCH re-entry after a timeout, restarts the wait count
  always_comb begin
    wait_d = wait_q;
    if ((state_d != state_q) || timeout) begin
      wait_d = '0;
    end else if (mem_phase && !bus.mem_ready) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_comb begin
    bus.pc_write  = 1'b0;
    bus.ir_write  = 1'b0;
    bus.alu_op    = '0;
    bus.alu_src   = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_2_reg = 1'b0;
    bus.reg_write = 1'b0;
    bus.branch    = 1'b0;
    bus.jump      = 1'b0;
    bus.IF_flush  = 1'b0;
    if (arst_n) begin
      case (state_q)
        ST_FETCH: begin
          bus.mem_read = 1'b1;
          bus.ir_write = bus.mem_ready;
          bus.pc_write = bus.mem_ready;
        end
        ST_EXEC: begin
          bus.alu_src = (cls == CLS_ALU_I) || (cls == CLS_LOAD) || (cls == CLS_STORE);
          case (cls)
            CLS_ALU_R:  bus.alu_op = ALU_OP_W'(ALU_OP_FUNCT);
            CLS_BRANCH: bus.alu_op = ALU_OP_W'(ALU_OP_BRANCH);
            default:    bus.alu_op = ALU_OP_W'(ALU_OP_ADD);
          endcase
          if (cls == CLS_BRANCH) begin
            bus.branch   = bus.branch_flag;
            bus.pc_write = bus.branch_flag;
            bus.IF_flush = bus.branch_flag;
          end
          if (cls == CLS_JUMP) begin
            bus.jump     = 1'b1;
            bus.pc_write = 1'b1;
            bus.IF_flush = 1'b1;
          end
        end
        ST_MEM: begin
          bus.mem_read  = (cls == CLS_LOAD);
          bus.mem_write = (cls == CLS_STORE);
        end
        ST_WB: begin
          bus.reg_write = 1'b1;
          bus.mem_2_reg = (cls == CLS_LOAD);
        end
        default: ;
      endcase
    end
  end

  assign bus.state     = state_q;
  assign bus.illegal   = illegal_q;
  assign bus.mem_error = mem_error_q;

`ifdef PERF_CNT_EN
  logic [31:0] retired_q;
  logic        retire;

  // Completed instructions only; illegal and timeout aborts fall through uncounted
  assign retire = (state_d == ST_FETCH) && !timeout &&
                  ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB));

  always_ff @(posedge clk) begin
    if (!arst_n)     retired_q <= '0;
    else if (retire) retired_q <= retired_q + 32'd1;
  end

  assign bus.instr_retired = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed scoreboard bench for multicycle_control_unit
module tb_multicycle_control_unit;

  localparam logic [11:0] F_PCW  = 12'h800;
  localparam logic [11:0] F_IRW  = 12'h400;
  localparam logic [11:0] F_SRC  = 12'h200;
  localparam logic [11:0] F_RD   = 12'h100;
  localparam logic [11:0] F_WR   = 12'h080;
  localparam logic [11:0] F_M2R  = 12'h040;
  localparam logic [11:0] F_RW   = 12'h020;
  localparam logic [11:0] F_BR   = 12'h010;
  localparam logic [11:0] F_JMP  = 12'h008;
  localparam logic [11:0] F_FL   = 12'h004;
  localparam logic [11:0] F_ILL  = 12'h002;
  localparam logic [11:0] F_MERR = 12'h001;
  localparam logic [11:0] F_FETCH = F_RD | F_IRW | F_PCW;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] J  = 7'b1101111;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BAD = 7'b1111111;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [16:0] exp_q[$];

  multicycle_control_unit_if #(.ALU_OP_W(2)) bus ();

  multicycle_control_unit #(.MEM_TIMEOUT(3), .ALU_OP_W(2)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] observed();
    return {bus.state, bus.alu_op, bus.pc_write, bus.ir_write, bus.alu_src,
            bus.mem_read, bus.mem_write, bus.mem_2_reg, bus.reg_write,
            bus.branch, bus.jump, bus.IF_flush, bus.illegal, bus.mem_error};
  endfunction

  task automatic step(input string tag, input logic rst, input logic [6:0] op,
                      input logic bf, input logic mr, input logic [2:0] st,
                      input logic [1:0] aop, input logic [11:0] fl);
    logic [16:0] got;
    logic [16:0] want;
    @(negedge clk);
    arst_n          = rst;
    bus.opcode      = op;
    bus.branch_flag = bf;
    bus.mem_ready   = mr;
    exp_q.push_back({st, aop, fl});
    #1;
    got  = observed();
    want = exp_q.pop_front();
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed state=%0d alu_op=%b flags=%b, expected state=%0d alu_op=%b flags=%b",
             tag, got[16:14], got[13:12], got[11:0], want[16:14], want[13:12], want[11:0]);
    end
  endtask

  initial begin
    bus.opcode = '0;
    bus.branch_flag = 1'b0;
    bus.mem_ready = 1'b0;

    step("reset_idle",   0, 7'd0, 0, 0, 0, 2'b00, 12'h000);
    step("reset_forced", 0, R,    1, 1, 0, 2'b00, 12'h000);

    step("alur_fetch",  1, R, 0, 1, 0, 2'b00, F_FETCH);
    step("alur_decode", 1, R, 0, 1, 1, 2'b00, 12'h000);
    step("alur_exec",   1, R, 0, 1, 2, 2'b10, 12'h000);
    step("alur_wb",     1, R, 0, 1, 4, 2'b00, F_RW);

    step("alui_fetch",  1, I, 0, 1, 0, 2'b00, F_FETCH);
    step("alui_decode", 1, I, 0, 1, 1, 2'b00, 12'h000);
    step("alui_exec",   1, I, 0, 1, 2, 2'b00, F_SRC);
    step("alui_wb",     1, I, 0, 1, 4, 2'b00, F_RW);

    step("load_fetch",  1, LD, 0, 1, 0, 2'b00, F_FETCH);
    step("load_decode", 1, LD, 0, 1, 1, 2'b00, 12'h000);
    step("load_exec",   1, LD, 0, 1, 2, 2'b00, F_SRC);
    step("load_wait1",  1, LD, 0, 0, 3, 2'b00, F_RD);
    step("load_wait2",  1, LD, 0, 0, 3, 2'b00, F_RD);
    step("load_wait3",  1, LD, 0, 0, 3, 2'b00, F_RD);
    step("load_ready_at_limit", 1, LD, 0, 1, 3, 2'b00, F_RD);
    step("load_wb",     1, LD, 0, 1, 4, 2'b00, F_RW | F_M2R);

    step("br1_fetch",   1, BR, 1, 1, 0, 2'b00, F_FETCH);
    step("br1_decode",  1, BR, 1, 1, 1, 2'b00, 12'h000);
    step("br1_exec",    1, BR, 1, 1, 2, 2'b01, F_BR | F_PCW | F_FL);
    step("br0_fetch",   1, BR, 0, 1, 0, 2'b00, F_FETCH);
    step("br0_decode",  1, BR, 0, 1, 1, 2'b00, 12'h000);
    step("br0_exec",    1, BR, 0, 1, 2, 2'b01, 12'h000);

    step("jump_fetch",  1, J, 0, 1, 0, 2'b00, F_FETCH);
    step("jump_decode", 1, J, 0, 1, 1, 2'b00, 12'h000);
    step("jump_exec",   1, J, 0, 1, 2, 2'b00, F_JMP | F_PCW | F_FL);

    step("store_fetch",  1, ST, 0, 1, 0, 2'b00, F_FETCH);
    step("store_decode", 1, ST, 0, 1, 1, 2'b00, 12'h000);
    step("store_exec",   1, ST, 0, 1, 2, 2'b00, F_SRC);
    step("store_mem",    1, ST, 0, 1, 3, 2'b00, F_WR);

    step("bad_fetch",   1, BAD, 0, 1, 0, 2'b00, F_FETCH);
    step("bad_decode",  1, BAD, 0, 1, 1, 2'b00, 12'h000);
    step("bad_back_to_fetch", 1, BAD, 0, 0, 0, 2'b00, F_RD | F_ILL);

    step("tmo_wait2",   1, ST, 0, 0, 0, 2'b00, F_RD | F_ILL);
    step("tmo_wait3",   1, ST, 0, 0, 0, 2'b00, F_RD | F_ILL);
    step("tmo_expire",  1, ST, 0, 0, 0, 2'b00, F_RD | F_ILL);
    step("tmo_flagged", 1, ST, 0, 0, 0, 2'b00, F_RD | F_ILL | F_MERR);
    step("tmo_recover", 1, ST, 0, 1, 0, 2'b00, F_FETCH | F_ILL | F_MERR);

    step("rst_store_decode", 1, ST, 0, 1, 1, 2'b00, F_ILL | F_MERR);
    step("rst_store_exec",   1, ST, 0, 1, 2, 2'b00, F_SRC | F_ILL | F_MERR);
    step("rst_store_mem",    0, ST, 0, 0, 3, 2'b00, F_ILL | F_MERR);
    step("rst_after",        1, ST, 0, 0, 0, 2'b00, F_RD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
